// File: rtl/mp_deserializer.sv
// Purpose: reassembles els_p consecutive width_p-bit words into one flattened frame (word k at [k*width_p +: width_p]).
// Latency: v_o rises one cycle after the frame-completing word is accepted.
// Backpressure: ready_o drops only while one frame waits behind an unconsumed output frame.
// Optional end-of-frame checking is compiled in with MP_DESERIALIZER_LAST_CHECK_EN (adds last_i / err_o).

module mp_deserializer #(
  parameter int width_p = 16,
  parameter int els_p   = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [width_p-1:0]         data_i,
  output logic                       v_o,
  output logic [els_p*width_p-1:0]   data_o,
  input  logic                       yumi_i
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
  ,
  input  logic                       last_i,
  output logic                       err_o
`endif
);

  localparam int                    cnt_w_lp   = $clog2(els_p);
  localparam logic [cnt_w_lp-1:0]   cnt_max_lp = cnt_w_lp'(els_p - 1);

  // COLLECT: gathering words. HOLD: a complete frame sits in the collection
  // buffer waiting for the output register. DROP: resynchronising to last_i.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DROP    = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic [els_p*width_p-1:0]   coll_q, coll_d;
  logic [els_p*width_p-1:0]   out_q, out_d;
  logic                       out_v_q, out_v_d;
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
  logic                       err_q, err_d;
`endif

  logic accept;
  logic last_word;
  logic out_free;
  logic take;

  // ready_o comes straight from the state register, so v_i/yumi_i never reach it.
  assign ready_o   = (state_q != HOLD);
  assign accept    = v_i & ready_o;
  assign last_word = (cnt_q == cnt_max_lp);
  // A yumi while nothing is valid is ignored.
  assign take      = yumi_i & out_v_q;
  assign out_free  = ~out_v_q | yumi_i;

  assign v_o    = out_v_q;
  assign data_o = out_q;
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
  assign err_o  = err_q;
`endif

  // Next-state: word placement, counter, frame hand-off and framing checks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    out_d   = out_q;
    out_v_d = out_v_q;
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
    err_d   = 1'b0;
`endif

    // Consumer drains the output; a pending or new frame may refill it below.
    if (take) begin
      out_v_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          coll_d[cnt_q*width_p +: width_p] = data_i;
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
          if (last_i && !last_word) begin
            // Early end-of-frame: abandon the partial frame.
            cnt_d = '0;
            err_d = 1'b1;
          end else if (!last_i && last_word) begin
            // Missing end-of-frame: abandon and skip to the next last_i.
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = DROP;
          end else if (last_word) begin
`else
          if (last_word) begin
`endif
            cnt_d = '0;
            if (out_free) begin
              out_d   = coll_d;
              out_v_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        // Output slot frees up: move the parked frame across, v_o stays high.
        if (take) begin
          out_d   = coll_q;
          out_v_d = 1'b1;
          state_d = COLLECT;
        end
      end

`ifdef MP_DESERIALIZER_LAST_CHECK_EN
      DROP: begin
        if (accept && last_i) begin
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
`endif

      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      coll_q  <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mp_deserializer.sv
// Bench for mp_deserializer: a small instance (els_p=4) against a frame-queue model,
// plus a default-size instance (els_p=256) streaming with yumi tied to v_o.
module tb_mp_deserializer;

  localparam int W  = 16;
  localparam int E  = 4;
  localparam int EB = 256;
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic           s_v = 1'b0, s_yumi = 1'b0, s_last = 1'b0;
  logic [W-1:0]   s_d = '0;
  logic           s_rdy, s_vo;
  logic [E*W-1:0] s_do;

  logic            b_v = 1'b0;
  logic [W-1:0]    b_d = '0;
  logic            b_rdy, b_vo, b_yumi;
  logic [EB*W-1:0] b_do;
  assign b_yumi = b_vo;

`ifdef MP_DESERIALIZER_LAST_CHECK_EN
  logic s_err, b_err;
  logic b_last = 1'b0;
`endif

  mp_deserializer #(.width_p(W), .els_p(E)) u_small (
    .clk_i(clk), .rst_n_i(rst_n), .v_i(s_v), .ready_o(s_rdy), .data_i(s_d),
    .v_o(s_vo), .data_o(s_do), .yumi_i(s_yumi)
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
    , .last_i(s_last), .err_o(s_err)
`endif
  );

  mp_deserializer #(.width_p(W)) u_big (
    .clk_i(clk), .rst_n_i(rst_n), .v_i(b_v), .ready_o(b_rdy), .data_i(b_d),
    .v_o(b_vo), .data_o(b_do), .yumi_i(b_yumi)
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
    , .last_i(b_last), .err_o(b_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: accepted words collect in pw; finished frames queue in fq.
  // fq[0] is what v_o/data_o show; the design can hold at most two frames.
  logic [W-1:0]   pw[$];
  logic [E*W-1:0] fq[$];
  bit             drop;
  bit             err_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pw.delete();
    fq.delete();
    drop    = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic y, input logic l);
    bit rdy;
    logic [E*W-1:0] f;
    rdy     = (fq.size() < 2);
    err_exp = 1'b0;
    if (y && fq.size() > 0) void'(fq.pop_front());
    if (v && rdy) begin
      if (drop) begin
        if (l) drop = 1'b0;
      end else begin
        pw.push_back(d);
        if (CHK && l && pw.size() < E) begin
          pw.delete();
          err_exp = 1'b1;
        end else if (pw.size() == E) begin
          if (CHK && !l) begin
            drop    = 1'b1;
            err_exp = 1'b1;
          end else begin
            for (int i = 0; i < E; i++) f[i*W +: W] = pw[i];
            fq.push_back(f);
          end
          pw.delete();
        end
      end
    end
  endtask

  // One clock: apply the inputs already driven, step the model, compare outputs.
  task automatic tick();
    logic pv, py, pl;
    logic [W-1:0] pd;
    pv = s_v; py = s_yumi; pl = s_last; pd = s_d;
    @(posedge clk);
    #1;
    model_step(pv, pd, py, pl);
    chk("v_o", s_vo, fq.size() > 0);
    chk("ready_o", s_rdy, fq.size() < 2);
    if (fq.size() > 0) chk("data_o", s_do, fq[0]);
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
    chk("err_o", s_err, err_exp);
`endif
  endtask

  task automatic send(input logic v, input logic [W-1:0] d, input logic l, input bit take);
    s_v    = v;
    s_d    = d;
    s_last = l;
    s_yumi = take && (fq.size() > 0);
    tick();
  endtask

  task automatic idle(input int n, input bit take);
    for (int i = 0; i < n; i++) send(1'b0, 16'hEEEE, 1'b0, take);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_v = 1'b0; s_yumi = 1'b0; s_last = 1'b0; b_v = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_v_o", s_vo, 1'b0);
    chk("rst_ready_o", s_rdy, 1'b1);
    chk("rst_data_o", s_do, '0);
    chk("rst_big_v_o", b_vo, 1'b0);
    chk("rst_big_ready_o", b_rdy, 1'b1);
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
    chk("rst_err_o", s_err, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // yumi_i is only legal while v_o is high.
  always @(posedge clk) begin
    if (rst_n && s_yumi) begin
      checks++;
      assert (s_vo === 1'b1) else begin
        errors++;
        $error("FAIL yumi_protocol: got v_o=%b expected 1", s_vo);
      end
    end
  end

  initial begin
    model_reset();
    #3;
    do_reset();
    idle(2, 1'b0);

    // Basic frame, yumi follows v_o.
    for (int i = 0; i < E; i++) send(1'b1, 16'h1000 + 16'(i), i == E-1, 1'b1);
    chk("t1_v", s_vo, 1'b1);
    chk("t1_frame", s_do, 64'h1003_1002_1001_1000);
    idle(2, 1'b1);

    // Two frames with no consumer: second parks, ready drops.
    for (int i = 0; i < 2*E; i++) send(1'b1, 16'h00A0 + 16'(i), (i % E) == E-1, 1'b0);
    chk("t2_ready_low", s_rdy, 1'b0);
    chk("t2_held", s_do, 64'h00A3_00A2_00A1_00A0);
    send(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t2_swap", s_do, 64'h00A7_00A6_00A5_00A4);
    chk("t2_v_cont", s_vo, 1'b1);
    chk("t2_ready_back", s_rdy, 1'b1);
    idle(2, 1'b1);

    // Reset with a held frame and a half-built one, then a fresh frame.
    for (int i = 0; i < E; i++) send(1'b1, 16'h00C0 + 16'(i), i == E-1, 1'b0);
    send(1'b1, 16'h0050, 1'b0, 1'b0);
    send(1'b1, 16'h0051, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < E; i++) send(1'b1, 16'h00B0 + 16'(i), i == E-1, 1'b1);
    chk("t4_frame", s_do, 64'h00B3_00B2_00B1_00B0);
    idle(2, 1'b1);

    // Gapped valid: only valid cycles are captured.
    send(1'b1, 16'h0011, 1'b0, 1'b1);
    send(1'b0, 16'hDEAD, 1'b1, 1'b1);
    send(1'b1, 16'h0022, 1'b0, 1'b1);
    send(1'b0, 16'hDEAD, 1'b1, 1'b1);
    send(1'b1, 16'h0033, 1'b0, 1'b1);
    send(1'b0, 16'hDEAD, 1'b1, 1'b1);
    send(1'b1, 16'h0044, 1'b1, 1'b1);
    chk("t6_frame", s_do, 64'h0044_0033_0022_0011);
    idle(2, 1'b1);

`ifdef MP_DESERIALIZER_LAST_CHECK_EN
    // Early last on the second word.
    send(1'b1, 16'h00D0, 1'b0, 1'b1);
    send(1'b1, 16'h00D1, 1'b1, 1'b1);
    chk("early_err", s_err, 1'b1);
    chk("early_no_v", s_vo, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < E; i++) send(1'b1, 16'h00E0 + 16'(i), i == E-1, 1'b1);
    chk("after_early_frame", s_do, 64'h00E3_00E2_00E1_00E0);
    idle(2, 1'b1);
    // Missing last, then resync on a fifth word carrying last.
    for (int i = 0; i < E; i++) send(1'b1, 16'h00F0 + 16'(i), 1'b0, 1'b1);
    chk("missing_err", s_err, 1'b1);
    send(1'b1, 16'h00F4, 1'b1, 1'b1);
    chk("drop_no_err", s_err, 1'b0);
    chk("drop_no_v", s_vo, 1'b0);
    for (int i = 0; i < E; i++) send(1'b1, 16'h0070 + 16'(i), i == E-1, 1'b1);
    chk("resync_frame", s_do, 64'h0073_0072_0071_0070);
    idle(2, 1'b1);
`endif

    // Random traffic with random consumer stalls.
    for (int n = 0; n < 400; n++) begin
      logic l;
      l = (pw.size() == E-1);
      if (CHK && $urandom_range(0, 7) == 0) l = ~l;
      send(1'($urandom_range(0, 1)), 16'($urandom), l, 1'($urandom_range(0, 1)));
    end
    idle(4, 1'b1);

    // Default size: two back-to-back frames, yumi tied to v_o.
    for (int i = 0; i < 2*EB; i++) begin
      b_v = 1'b1;
      b_d = 16'(1000 + i);
`ifdef MP_DESERIALIZER_LAST_CHECK_EN
      b_last = ((i % EB) == EB-1);
`endif
      tick();
      chk("big_ready", b_rdy, 1'b1);
      if ((i % EB) == EB-1) begin
        chk("big_v_hi", b_vo, 1'b1);
        for (int j = 0; j < EB; j++)
          chk("big_elem", b_do[j*W +: W], 64'(16'(1000 + (i - (EB-1)) + j)));
      end else begin
        chk("big_v_lo", b_vo, 1'b0);
      end
    end
    b_v = 1'b0;
    tick();
    chk("big_v_drain", b_vo, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp_deserializer.md
Name: mp_deserializer

Overview:
- Receive-side counterpart of mp_serializer.
- Accepts a stream of width_p-bit words, one per cycle under a valid/ready handshake.
- Reassembles every els_p consecutive words into one els_p*width_p-bit frame using the same flattened layout the serializer consumes.
- Presents each frame under a valid/yumi handshake. Single clock domain, placed at the destination end of a serial link.

Parameters:
- width_p, 16, bits per serial word.
- els_p, 256, words per frame; legal range is els_p >= 2.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  asynchronous active-low reset.
- v_i  input  1  data_i valid.
- ready_o  output  1  block can accept a word this cycle.
- data_i  input  width_p  serial word.
- v_o  output  1  complete frame on data_o.
- data_o  output  els_p*width_p  assembled frame.
- yumi_i  input  1  consumer takes the frame; legal only when v_o=1.
- last_i  input  1  end-of-frame marker; present only with MP_DESERIALIZER_LAST_CHECK_EN.
- err_o  output  1  framing error pulse; present only with MP_DESERIALIZER_LAST_CHECK_EN.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - v_o=0, data_o=0, ready_o=1.
  - Word counter cnt_r=0, full_r=0, err_o=0.
  - Any partial frame is discarded.
- Input transfer occurs on a clock edge where v_i=1 and ready_o=1. data_i is ignored otherwise.
- Word placement: the k-th accepted word of a frame (k=0..els_p-1) is written to collection slice [(k+1)*width_p-1 : k*width_p]. The first word received is element 0.
- cnt_r is $clog2(els_p) bits wide, increments per accepted word, and wraps to 0 after the word accepted at cnt_r=els_p-1 (the frame-complete word).
- Storage: one collection buffer plus one output register. Each holds a full frame.
- ready_o = ~full_r, registered with no combinational path from v_i or yumi_i.
- Frame complete while output free (v_o=0, or v_o=1 with yumi_i=1 in the same cycle):
  - Output register loads the frame on the following edge; v_o=1 one cycle after the last word is accepted.
  - ready_o stays 1.
- Frame complete while output occupied (v_o=1, yumi_i=0):
  - full_r sets and ready_o=0 from the next cycle.
- full_r=1 and yumi_i=1:
  - Output loads the collection buffer on that edge; v_o stays 1 and full_r clears.
  - ready_o=1 the following cycle (one bubble).
- yumi_i=1 with no pending frame: v_o=0 on the next cycle.
- data_o holds stable while v_o=1 and yumi_i=0.
- Throughput: with yumi_i asserted whenever v_o=1, back-to-back frames stream with ready_o permanently 1 and v_o high for one cycle per frame.
- yumi_i while v_o=0 is a protocol violation. The bench asserts on it; the design ignores it.
- States: COLLECT (full_r=0) and HOLD (full_r=1). The output register valid bit is independent of these states.

Optional Feature:
MP_DESERIALIZER_LAST_CHECK_EN
- Defined: last_i and err_o ports exist. The legal pattern is last_i=1 on exactly the word accepted at cnt_r=els_p-1.
  - Early last (last_i=1, cnt_r<els_p-1): discard the partial frame including this word; cnt_r=0; err_o=1 for one cycle after.
  - Missing last (last_i=0 at cnt_r=els_p-1): discard the frame and pulse err_o once. Enter DROP state with ready_o=1, discarding accepted words until one with last_i=1 is accepted, then return to COLLECT with cnt_r=0.
  - Error-free traffic behaves identically to the undefined case.
- Undefined: no last_i/err_o ports; framing is by count only.

Test Plan:
- els_p=4, width_p=16. Reset, then words 0x1000,0x1001,0x1002,0x1003 on consecutive cycles with yumi_i tied to v_o. Expect v_o=1 exactly one cycle after the 4th accept and data_o=0x1003_1002_1001_1000.
- els_p=4, yumi_i=0. Send 8 consecutive words 0xA0..0xA7. Expect frame 0xA3..A0 held on data_o, ready_o=0 after 0xA7 is accepted. Then pulse yumi_i: data_o=0xA7..A4 next cycle, v_o continuous, ready_o=1 one cycle later.
- Default els_p=256. Stream words 1000..1255 continuously with yumi_i tied to v_o. Expect element j = 1000+j and ready_o never deasserted.
- Assert rst_n_i low after 2 of 4 words, then send a fresh 4-word frame 0xB0..0xB3. Expect outputs immediately at reset values and the emitted frame exactly 0xB3..B0, with no stale words.
- With MP_DESERIALIZER_LAST_CHECK_EN, els_p=4:
  - last_i on the 2nd word: expect an err_o pulse and no v_o.
  - Then send 4 words with last_i on the 4th: expect a valid frame.
  - Then 4 words without last_i followed by a 5th with last_i: expect one err_o pulse, no v_o, and the next correct frame accepted.
- v_i toggling 1,0,1,0 with words 0x11,0x22,0x33,0x44 (els_p=4). Expect only the valid cycles to be captured and data_o=0x0044_0033_0022_0011.
